// File: rtl/memory_arbiter.sv
// Round-robin RAM arbiter: one RAM transaction at a time across the data
// and instruction ports of CPUS cores, with address/data latching,
// abandon detection and a BUSY timeout.
//
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   iREN/iaddr                 instruction read request/address per core
//   dREN/dWEN/daddr/dstore     data read/write request, address, store data
//   iwait/dwait                per-port stall (combinational)
//   iload/dload                per-port read data (combinational)
//   err                        per-core abort pulse (combinational)
//   ramaddr/ramstore           latched RAM address/write data (registered)
//   ramREN/ramWEN              RAM enables (registered)
//   ramload/ramstate           RAM read data and status
module memory_arbiter #(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [32*CPUS-1:0]   iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [32*CPUS-1:0]   daddr,
  input  logic [32*CPUS-1:0]   dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [32*CPUS-1:0]   iload,
  output logic [32*CPUS-1:0]   dload,
  output logic [CPUS-1:0]      err,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  output logic                 ramREN,
  output logic                 ramWEN,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
);

  localparam int unsigned N  = 2 * CPUS;
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   g, g_n, p, p_n;
  logic [31:0]     addr_n, store_n;
  logic            wr, wr_n, ren_n, wen_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [N-1:0]    active;
  logic            found;
  logic [GW-1:0]   sel;
  logic [31:0]     sel_addr, sel_store;
  logic            sel_wr;
  logic            timed_out, fail, done;
  logic [GW-1:0]   g_next;

  // Requester r: 2c = data port of core c, 2c+1 = instruction port of core c
  always_comb begin
    active = '0;
    for (int unsigned c = 0; c < CPUS; c++) begin
      active[2*c]   = dREN[c] | dWEN[c];
      active[2*c+1] = iREN[c];
    end
  end

  // First active requester scanning from the rotating pointer
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(p) + i) % N;
      if (!found && active[GW'(idx)]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  // Payload of the selected requester
  always_comb begin
    sel_addr  = '0;
    sel_store = '0;
    sel_wr    = 1'b0;
    for (int unsigned c = 0; c < CPUS; c++) begin
      if (sel == GW'(2*c)) begin
        sel_addr  = daddr[32*c +: 32];
        sel_store = dstore[32*c +: 32];
        sel_wr    = dWEN[c];
      end else if (sel == GW'(2*c+1)) begin
        sel_addr  = iaddr[32*c +: 32];
      end
    end
  end

  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign fail      = (ramstate == RAM_ERROR) || timed_out;
  // Abandon, completion and failure all release the grant the same way
  assign done      = !active[g] || (ramstate == RAM_ACCESS) || fail;
  assign g_next    = (g == GW'(N - 1)) ? '0 : g + GW'(1);

  // Next-state logic
  always_comb begin
    state_n = state;
    g_n     = g;
    p_n     = p;
    addr_n  = ramaddr;
    store_n = ramstore;
    wr_n    = wr;
    cnt_n   = cnt;
    ren_n   = 1'b0;
    wen_n   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          g_n     = sel;
          addr_n  = sel_addr;
          store_n = sel_store;
          wr_n    = sel_wr;
          cnt_n   = '0;
          ren_n   = !sel_wr;
          wen_n   = sel_wr;
        end
      end
      BUSY: begin
        cnt_n = cnt + CW'(1);
        ren_n = ramREN;
        wen_n = ramWEN;
        if (done) begin
          state_n = IDLE;
          p_n     = g_next;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      g        <= '0;
      p        <= '0;
      ramaddr  <= '0;
      ramstore <= '0;
      wr       <= 1'b0;
      cnt      <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
    end else begin
      state    <= state_n;
      g        <= g_n;
      p        <= p_n;
      ramaddr  <= addr_n;
      ramstore <= store_n;
      wr       <= wr_n;
      cnt      <= cnt_n;
      ramREN   <= ren_n;
      ramWEN   <= wen_n;
    end
  end

  // Port-side responses; an abandoned grant gets neither wait-low nor err
  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    err   = '0;
    if (state == BUSY && active[g]) begin
      for (int unsigned c = 0; c < CPUS; c++) begin
        if (ramstate == RAM_ACCESS) begin
          if (g == GW'(2*c)) begin
            dwait[c]          = 1'b0;
            dload[32*c +: 32] = ramload;
          end else if (g == GW'(2*c+1)) begin
            iwait[c]          = 1'b0;
            iload[32*c +: 32] = ramload;
          end
        end else if (fail && (g == GW'(2*c) || g == GW'(2*c+1))) begin
          err[c] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (CPUS=2, TIMEOUT=8).
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait, err;
  logic [63:0] iload, dload;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ramREN, ramWEN;
  logic [1:0]  ramstate;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.CPUS(2), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .err(err),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
  endtask

  initial begin
    int r;
    logic [1:0] exp_i, exp_d;

    // Reset with every request high
    clear_inputs();
    RST = 1'b1;
    iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11;
    step(); step();
    #2;
    check("rst_ren", 64'(ramREN), 64'(0));
    check("rst_wen", 64'(ramWEN), 64'(0));
    check("rst_waits", 64'({iwait, dwait}), 64'(4'hF));
    check("rst_err", 64'(err), 64'(0));
    check("rst_addr", 64'(ramaddr), 64'(0));
    RST = 1'b0;
    clear_inputs();
    step();

    // Single instruction read on core 1, ACCESS in cycle 3
    iREN = 2'b10; iaddr[63:32] = 32'h100;
    #2;
    check("rd_c0_wait", 64'(iwait), 64'(2'b11));
    step(); ramstate = 2'd1; #2;
    check("rd_c1_addr", 64'(ramaddr), 64'h100);
    check("rd_c1_ren", 64'({ramREN, ramWEN}), 64'(2'b10));
    step(); #2;
    check("rd_c2_wait", 64'(iwait), 64'(2'b11));
    step(); ramstate = 2'd2; ramload = 32'hDEADBEEF; #2;
    check("rd_c3_iwait", 64'(iwait), 64'(2'b01));
    check("rd_c3_iload", iload, 64'hDEADBEEF_00000000);
    check("rd_c3_dwait", 64'(dwait), 64'(2'b11));
    step(); iREN = '0; ramstate = 2'd0; ramload = '0; #2;
    check("rd_c4_ren", 64'(ramREN), 64'(0));
    check("rd_c4_iwait", 64'(iwait), 64'(2'b11));

    // Round-robin with all four requesters active, RAM always ACCESS
    dREN = 2'b11; iREN = 2'b11;
    daddr = {32'h30, 32'h10};
    iaddr = {32'h40, 32'h20};
    ramstate = 2'd2; ramload = 32'h5555;
    for (int t = 0; t < 5; t++) begin
      r = t % 4;
      #2;
      check("rr_idle_waits", 64'({iwait, dwait}), 64'(4'hF));
      step(); #2;
      exp_i = 2'b11; exp_d = 2'b11;
      if (r % 2 == 0) exp_d[r/2] = 1'b0; else exp_i[r/2] = 1'b0;
      check("rr_addr", 64'(ramaddr), 64'(32'h10 * (r + 1)));
      check("rr_waits", 64'({iwait, dwait}), 64'({exp_i, exp_d}));
      step();
    end
    clear_inputs();

    // Write latching on core 0 data port
    dWEN = 2'b01; daddr[31:0] = 32'h40; dstore[31:0] = 32'h1234;
    step(); ramstate = 2'd1; #2;
    check("wr_c1_addr", 64'(ramaddr), 64'h40);
    check("wr_c1_store", 64'(ramstore), 64'h1234);
    check("wr_c1_en", 64'({ramREN, ramWEN}), 64'(2'b01));
    step(); daddr[31:0] = 32'h80; dstore[31:0] = 32'hFFFF; #2;
    check("wr_c2_addr", 64'(ramaddr), 64'h40);
    check("wr_c2_store", 64'(ramstore), 64'h1234);
    step(); ramstate = 2'd2; #2;
    check("wr_c3_dwait", 64'(dwait), 64'(2'b10));
    check("wr_c3_addr", 64'(ramaddr), 64'h40);
    step(); clear_inputs(); #2;
    check("wr_c4_wen", 64'(ramWEN), 64'(0));

    // Timeout on core 0 data read, then ERROR on core 1 data read
    dREN = 2'b01; daddr[31:0] = 32'h50;
    step(); ramstate = 2'd1; dREN = 2'b11; daddr[63:32] = 32'h60; #2;
    check("to_c1_addr", 64'(ramaddr), 64'h50);
    repeat (6) step();
    #2;
    check("to_c7_err", 64'(err), 64'(0));
    step(); #2;
    check("to_c8_err", 64'(err), 64'(2'b01));
    check("to_c8_dwait", 64'(dwait), 64'(2'b11));
    step(); dREN = 2'b10; #2;
    check("to_c9_ren", 64'(ramREN), 64'(0));
    check("to_c9_err", 64'(err), 64'(0));
    step(); ramstate = 2'd3; #2;
    check("er_addr", 64'(ramaddr), 64'h60);
    check("er_err", 64'(err), 64'(2'b10));
    check("er_dwait", 64'(dwait), 64'(2'b11));
    step(); clear_inputs(); #2;
    check("er_after_err", 64'(err), 64'(0));
    check("er_after_ren", 64'(ramREN), 64'(0));

    // Abandon: core 1 instruction port drops request mid-BUSY
    iREN = 2'b10; iaddr[63:32] = 32'h70;
    step(); ramstate = 2'd1; #2;
    check("ab_c1_ren", 64'(ramREN), 64'(1));
    check("ab_c1_addr", 64'(ramaddr), 64'h70);
    step(); iREN = '0; #2;
    check("ab_c2_iwait", 64'(iwait), 64'(2'b11));
    check("ab_c2_err", 64'(err), 64'(0));
    check("ab_c2_ren", 64'(ramREN), 64'(1));
    step(); #2;
    check("ab_c3_ren", 64'(ramREN), 64'(0));
    check("ab_c3_err", 64'(err), 64'(0));

    // Pointer moved past the abandoned requester: r0 first, then r1
    dREN = 2'b01; iREN = 2'b01;
    daddr[31:0] = 32'h90; iaddr[31:0] = 32'hA0;
    step(); ramstate = 2'd2; #2;
    check("ptr_r0_addr", 64'(ramaddr), 64'h90);
    step(); #2;
    step(); #2;
    check("ptr_r1_addr", 64'(ramaddr), 64'hA0);
    check("ptr_r1_iwait", 64'(iwait), 64'(2'b10));

    // Reset during BUSY aborts without err
    step(); iREN = '0; dREN = 2'b01; ramstate = 2'd1;
    step(); #2;
    check("rb_ren", 64'(ramREN), 64'(1));
    RST = 1'b1;
    step(); #2;
    check("rb_ren_after", 64'(ramREN), 64'(0));
    check("rb_err", 64'(err), 64'(0));
    check("rb_dwait", 64'(dwait), 64'(2'b11));
    RST = 1'b0;
    clear_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
